// File: rtl/turbo_frame_ctrl.sv
// Turbo encoder frame controller: buffers K systematic bits, steps two RSC encoders
// through data and termination phases, and registers the coded (x, z1, z2) triples.
module turbo_frame_ctrl #(
  parameter int K_MAX = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_N,
  input  logic          start,
  input  logic [AW:0]   frame_len,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  output logic [AW-1:0] il_addr,
  input  logic [AW-1:0] il_data,
  output logic          enc_rst,
  output logic          enc1_bin,
  output logic          enc1_mode,
  output logic          enc2_bin,
  output logic          enc2_mode,
  input  logic          enc1_x,
  input  logic          enc1_z,
  input  logic          enc2_x,
  input  logic          enc2_z,
  output logic          out_valid,
  output logic          out_x,
  output logic          out_z1,
  output logic          out_z2,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] K_MAX_L = (AW+1)'(K_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, ENC, TAIL1, TAIL2, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    tail_q, tail_d;
  logic [AW:0]   k_q, k_d;
  logic          bit_buf [DEPTH];
  logic          len_ok;
  logic          cnt_last;
  logic          tail_last;

  assign len_ok    = (frame_len != '0) && (frame_len <= K_MAX_L);
  assign cnt_last  = ({1'b0, cnt_q} == (k_q - 1'b1));
  assign tail_last = (tail_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tail_d    = tail_q;
    k_d       = k_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    enc_rst   = 1'b1;
    enc1_mode = 1'b0;
    enc2_mode = 1'b0;
    il_addr   = '0;
    enc1_bin  = 1'b0;
    enc2_bin  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && len_ok) begin
          state_d = LOAD;
          k_d     = frame_len;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (cnt_last) begin
            state_d = ENC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ENC: begin
        busy     = 1'b1;
        enc_rst  = 1'b0;
        il_addr  = cnt_q;
        enc1_bin = bit_buf[cnt_q];
        enc2_bin = bit_buf[il_data];
        if (cnt_last) begin
          state_d = TAIL1;
          tail_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TAIL1: begin
        busy      = 1'b1;
        enc_rst   = 1'b0;
        enc1_mode = 1'b1;
        enc2_mode = 1'b1;
        if (tail_last) begin
          state_d = TAIL2;
          tail_d  = '0;
        end else begin
          tail_d = tail_q + 2'd1;
        end
      end
      TAIL2: begin
        busy      = 1'b1;
        enc_rst   = 1'b0;
        enc1_mode = 1'b1;
        enc2_mode = 1'b1;
        if (tail_last) begin
          state_d = DONE;
        end else begin
          tail_d = tail_q + 2'd1;
        end
      end
      DONE: begin
        busy    = 1'b1;
        enc_rst = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so hold the decoded controls quiet while it is asserted.
    if (!rst_N) begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      enc_rst   = 1'b1;
      enc1_mode = 1'b0;
      enc2_mode = 1'b0;
      il_addr   = '0;
      enc1_bin  = 1'b0;
      enc2_bin  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tail_q    <= '0;
      k_q       <= '0;
      out_valid <= 1'b0;
      out_x     <= 1'b0;
      out_z1    <= 1'b0;
      out_z2    <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tail_q    <= tail_d;
      k_q       <= k_d;
      out_valid <= (state_q == ENC) || (state_q == TAIL1) || (state_q == TAIL2);
      out_last  <= (state_q == TAIL2) && tail_last;
      done      <= (state_q == DONE);
      err       <= (state_q == IDLE) && start && !len_ok;
      case (state_q)
        ENC: begin
          out_x  <= bit_buf[cnt_q];
          out_z1 <= enc1_z;
          out_z2 <= enc2_z;
        end
        TAIL1: begin
          out_x  <= enc1_x;
          out_z1 <= enc1_z;
          out_z2 <= 1'b0;
        end
        TAIL2: begin
          out_x  <= enc2_x;
          out_z1 <= 1'b0;
          out_z2 <= enc2_z;
        end
        default: begin
          out_x  <= 1'b0;
          out_z1 <= 1'b0;
          out_z2 <= 1'b0;
        end
      endcase
    end
  end

  // The bit buffer is deliberately left out of reset; stale contents stay readable.
  always_ff @(posedge clk) begin
    if (rst_N && (state_q == LOAD) && in_valid) begin
      bit_buf[cnt_q] <= in_bit;
    end
  end

endmodule

// File: tb/tb_turbo_frame_ctrl.sv
// Self-checking bench for turbo_frame_ctrl: surrounding RSC encoder pair, interleaver table,
// and a reference model that derives the coded beat sequence from the frame bits directly.
module tb_turbo_frame_ctrl;
  localparam int K_MAX = 256;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_N = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   frame_len = '0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_ready;
  logic [AW-1:0] il_addr, il_data;
  logic          enc_rst, enc1_bin, enc1_mode, enc2_bin, enc2_mode;
  logic          enc1_x, enc1_z, enc2_x, enc2_z;
  logic          out_valid, out_x, out_z1, out_z2, out_last, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  int perm [DEPTH];
  bit ref_mem [DEPTH];
  bit frame_bits [K_MAX];

  bit cap_x[$], cap_z1[$], cap_z2[$], cap_last[$], cap_e1[$], cap_e2[$];
  int cap_addr[$];
  bit exp_x[$], exp_z1[$], exp_z2[$], exp_last[$], exp_e2[$];
  int first_beat, last_beat, done_cyc, done_cnt, err_cnt, acc_cnt, busy_at_done;
  bit load_ok;

  logic [2:0] e1s = '0;
  logic [2:0] e2s = '0;
  int         e2_hold = 0;
  logic       fb1, fb2;

  turbo_frame_ctrl #(.K_MAX(K_MAX), .AW(AW)) dut (
    .clk(clk), .rst_N(rst_N), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .il_addr(il_addr), .il_data(il_data), .enc_rst(enc_rst),
    .enc1_bin(enc1_bin), .enc1_mode(enc1_mode), .enc2_bin(enc2_bin), .enc2_mode(enc2_mode),
    .enc1_x(enc1_x), .enc1_z(enc1_z), .enc2_x(enc2_x), .enc2_z(enc2_z),
    .out_valid(out_valid), .out_x(out_x), .out_z1(out_z1), .out_z2(out_z2), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign il_data = AW'(perm[il_addr]);

  // RSC pair (feedback 1+D^2+D^3, parity 1+D+D^3); encoder 2 holds for its first 3 tail cycles.
  always_comb begin
    fb1 = enc1_mode ? 1'b0 : (enc1_bin ^ e1s[1] ^ e1s[2]);
    fb2 = enc2_mode ? 1'b0 : (enc2_bin ^ e2s[1] ^ e2s[2]);
  end
  assign enc1_x = enc1_mode ? (e1s[1] ^ e1s[2]) : enc1_bin;
  assign enc1_z = fb1 ^ e1s[0] ^ e1s[2];
  assign enc2_x = enc2_mode ? (e2s[1] ^ e2s[2]) : enc2_bin;
  assign enc2_z = fb2 ^ e2s[0] ^ e2s[2];

  always @(posedge clk) begin
    if (enc_rst) begin
      e1s     <= '0;
      e2s     <= '0;
      e2_hold <= 0;
    end else begin
      e1s <= {e1s[1:0], fb1};
      if (enc2_mode && e2_hold < 3) e2_hold <= e2_hold + 1;
      else e2s <= {e2s[1:0], fb2};
    end
  end

  function automatic int rsc_fb(int st, int u);
    return (u ^ (st >> 1) ^ (st >> 2)) & 1;
  endfunction
  function automatic int rsc_z(int st, int u);
    return (rsc_fb(st, u) ^ st ^ (st >> 2)) & 1;
  endfunction
  function automatic int rsc_next(int st, int u);
    return ((st << 1) | rsc_fb(st, u)) & 7;
  endfunction
  function automatic int rsc_tail_u(int st);
    return ((st >> 1) ^ (st >> 2)) & 1;
  endfunction

  // Expected frame: K data beats, 3 beats terminating encoder 1, 3 beats terminating encoder 2.
  task automatic build_expected(input int k);
    int s1, s2, u1, u2, u;
    exp_x.delete(); exp_z1.delete(); exp_z2.delete(); exp_last.delete(); exp_e2.delete();
    s1 = 0;
    s2 = 0;
    for (int i = 0; i < k; i++) begin
      u1 = int'(frame_bits[i]);
      u2 = int'(ref_mem[perm[i] % DEPTH]);
      exp_e2.push_back(bit'(u2));
      exp_x.push_back(bit'(u1));
      exp_z1.push_back(bit'(rsc_z(s1, u1)));
      exp_z2.push_back(bit'(rsc_z(s2, u2)));
      exp_last.push_back(1'b0);
      s1 = rsc_next(s1, u1);
      s2 = rsc_next(s2, u2);
    end
    for (int j = 0; j < 3; j++) begin
      u = rsc_tail_u(s1);
      exp_x.push_back(bit'(u)); exp_z1.push_back(bit'(rsc_z(s1, u))); exp_z2.push_back(1'b0);
      exp_last.push_back(1'b0);
      s1 = rsc_next(s1, u);
    end
    for (int j = 0; j < 3; j++) begin
      u = rsc_tail_u(s2);
      exp_x.push_back(bit'(u)); exp_z1.push_back(1'b0); exp_z2.push_back(bit'(rsc_z(s2, u)));
      exp_last.push_back(j == 2);
      s2 = rsc_next(s2, u);
    end
  endtask

  task automatic do_load(input int k, input int vmode);
    @(negedge clk);
    start     = 1'b1;
    frame_len = (AW+1)'(k);
    @(negedge clk);
    start   = 1'b0;
    acc_cnt = 0;
    load_ok = 1'b1;
    for (int cyc = 0; cyc < 4 * k + 20 && acc_cnt < k; cyc++) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 1);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_bit = frame_bits[acc_cnt];
      if (in_ready !== 1'b1) load_ok = 1'b0;
      if (in_valid && in_ready === 1'b1) begin
        ref_mem[acc_cnt] = frame_bits[acc_cnt];
        acc_cnt++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_run(input int k, input bit poke);
    cap_x.delete(); cap_z1.delete(); cap_z2.delete(); cap_last.delete();
    cap_e1.delete(); cap_e2.delete(); cap_addr.delete();
    first_beat = -1; last_beat = -1; done_cyc = -1; done_cnt = 0; err_cnt = 0; busy_at_done = 1;
    for (int c = 0; c < k + 12; c++) begin
      if (c < k) begin
        cap_e1.push_back(enc1_bin); cap_e2.push_back(enc2_bin); cap_addr.push_back(int'(il_addr));
      end
      if (out_valid === 1'b1) begin
        cap_x.push_back(out_x); cap_z1.push_back(out_z1); cap_z2.push_back(out_z2);
        cap_last.push_back(out_last);
        if (first_beat < 0) first_beat = c;
        last_beat = c;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = int'(busy);
        end
      end
      if (err === 1'b1) err_cnt++;
      if (poke && c < k + 5) begin
        start     = 1'($urandom_range(0, 1));
        frame_len = (AW+1)'($urandom_range(0, 300));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_N = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, out_x, out_z1, out_z2, out_last} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b, expected 000000",
               {in_ready, out_valid, out_x, out_z1, out_z2, out_last});
    end
    n_tests++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_status: got %b, expected 000", {busy, done, err});
    end
    n_tests++;
    if ({enc_rst, enc1_mode, enc2_mode} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL reset_enc: got %b, expected 100", {enc_rst, enc1_mode, enc2_mode});
    end
    n_tests++;
    if (il_addr !== '0) begin
      n_fail++; $display("[TB] FAIL reset_il_addr: got %0d, expected 0", il_addr);
    end
    rst_N = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, in_ready, enc_rst} !== 3'b001) begin
      n_fail++; $display("[TB] FAIL idle_after_reset: got %b, expected 001", {busy, in_ready, enc_rst});
    end
  endtask

  task automatic test_zero_frame;
    for (int i = 0; i < 8; i++) frame_bits[i] = 1'b0;
    do_load(8, 0);
    build_expected(8);
    do_run(8, 1'b0);
    n_tests++;
    if (cap_x.size() !== 14) begin
      n_fail++; $display("[TB] FAIL zero_beats: got %0d, expected 14", cap_x.size());
    end
    for (int b = 0; b < cap_x.size() && b < exp_x.size(); b++) begin
      n_tests++;
      if ({cap_x[b], cap_z1[b], cap_z2[b], cap_last[b]} !== {3'b000, b == 13}) begin
        n_fail++;
        $display("[TB] FAIL zero_beat%0d: got x/z1/z2/last %b%b%b%b, expected 000%b", b + 1,
                 cap_x[b], cap_z1[b], cap_z2[b], cap_last[b], b == 13);
      end
    end
    n_tests++;
    if (done_cyc !== last_beat + 1 || done_cnt !== 1 || busy_at_done !== 0) begin
      n_fail++;
      $display("[TB] FAIL zero_done: got done at %0d (x%0d, busy %0d), expected at %0d once, busy 0",
               done_cyc, done_cnt, busy_at_done, last_beat + 1);
    end
  endtask

  task automatic test_pattern;
    logic [3:0] obs_x;
    int         z_diff;
    frame_bits[0] = 1'b1; frame_bits[1] = 1'b0; frame_bits[2] = 1'b1; frame_bits[3] = 1'b1;
    do_load(4, 0);
    build_expected(4);
    do_run(4, 1'b0);
    n_tests++;
    if (cap_x.size() !== 10) begin
      n_fail++; $display("[TB] FAIL pattern_beats: got %0d, expected 10", cap_x.size());
    end
    obs_x  = '0;
    z_diff = 0;
    for (int b = 0; b < 4 && b < cap_x.size(); b++) begin
      obs_x[3-b] = cap_x[b];
      if (cap_z1[b] !== cap_z2[b]) z_diff++;
    end
    n_tests++;
    if (obs_x !== 4'b1011) begin
      n_fail++; $display("[TB] FAIL pattern_x: got %b, expected 1011", obs_x);
    end
    n_tests++;
    if (z_diff !== 0) begin
      n_fail++; $display("[TB] FAIL pattern_z1_eq_z2: got %0d differing beats, expected 0", z_diff);
    end
    for (int b = 4; b < cap_x.size() && b < exp_x.size(); b++) begin
      n_tests++;
      if ({cap_x[b], cap_z1[b], cap_z2[b], cap_last[b]} !== {exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]}) begin
        n_fail++;
        $display("[TB] FAIL pattern_beat%0d: got %b%b%b%b, expected %b%b%b%b", b + 1,
                 cap_x[b], cap_z1[b], cap_z2[b], cap_last[b], exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]);
      end
    end
  endtask

  task automatic test_bad_len;
    int lens [2];
    lens[0] = 0;
    lens[1] = K_MAX + 1;
    foreach (lens[n]) begin
      @(negedge clk);
      start     = 1'b1;
      frame_len = (AW+1)'(lens[n]);
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if ({err, busy, in_ready} !== 3'b100) begin
        n_fail++;
        $display("[TB] FAIL bad_len%0d_pulse: got err/busy/ready %b, expected 100", lens[n], {err, busy, in_ready});
      end
      @(negedge clk);
      n_tests++;
      if ({err, busy, in_ready} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL bad_len%0d_after: got err/busy/ready %b, expected 000", lens[n], {err, busy, in_ready});
      end
    end
  endtask

  task automatic test_gap_load;
    for (int i = 0; i < 10; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    do_load(10, 1);
    n_tests++;
    if (acc_cnt !== 10 || load_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL gap_accepts: got %0d accepts (ready held %0d), expected 10 (1)", acc_cnt, load_ok);
    end
    n_tests++;
    if ({in_ready, enc_rst} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL gap_enc_entry: got ready/enc_rst %b, expected 00", {in_ready, enc_rst});
    end
    build_expected(10);
    do_run(10, 1'b0);
    n_tests++;
    if (cap_x.size() !== 16 || first_beat !== 1 || last_beat !== 16) begin
      n_fail++;
      $display("[TB] FAIL gap_beats: got %0d beats at %0d..%0d, expected 16 at 1..16",
               cap_x.size(), first_beat, last_beat);
    end
    for (int b = 0; b < cap_x.size() && b < exp_x.size(); b++) begin
      n_tests++;
      if ({cap_x[b], cap_z1[b], cap_z2[b], cap_last[b]} !== {exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]}) begin
        n_fail++;
        $display("[TB] FAIL gap_beat%0d: got %b%b%b%b, expected %b%b%b%b", b + 1,
                 cap_x[b], cap_z1[b], cap_z2[b], cap_last[b], exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]);
      end
    end
  endtask

  task automatic test_reversed;
    logic [3:0] obs_e2;
    for (int i = 0; i < 4; i++) perm[i] = 3 - i;
    frame_bits[0] = 1'b1; frame_bits[1] = 1'b0; frame_bits[2] = 1'b0; frame_bits[3] = 1'b0;
    do_load(4, 0);
    build_expected(4);
    do_run(4, 1'b0);
    obs_e2 = '0;
    for (int i = 0; i < 4 && i < cap_e2.size(); i++) obs_e2[3-i] = cap_e2[i];
    n_tests++;
    if (obs_e2 !== 4'b0001) begin
      n_fail++; $display("[TB] FAIL reversed_enc2_bin: got %b, expected 0001", obs_e2);
    end
    for (int b = 0; b < cap_x.size() && b < exp_x.size(); b++) begin
      n_tests++;
      if ({cap_x[b], cap_z1[b], cap_z2[b], cap_last[b]} !== {exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]}) begin
        n_fail++;
        $display("[TB] FAIL reversed_beat%0d: got %b%b%b%b, expected %b%b%b%b", b + 1,
                 cap_x[b], cap_z1[b], cap_z2[b], cap_last[b], exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]);
      end
    end
    for (int i = 0; i < 4; i++) perm[i] = i;
  endtask

  task automatic test_reset_mid_enc;
    int stray;
    for (int i = 0; i < 6; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    do_load(6, 0);
    @(negedge clk);
    rst_N = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, out_valid, in_ready, enc_rst} !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL abort_state: got busy/valid/ready/enc_rst %b, expected 0001",
               {busy, out_valid, in_ready, enc_rst});
    end
    rst_N = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) stray++;
    end
    n_tests++;
    if (stray !== 0) begin
      n_fail++; $display("[TB] FAIL abort_quiet: got %0d active cycles, expected 0", stray);
    end
    frame_bits[0] = 1'($urandom_range(0, 1));
    do_load(1, 0);
    build_expected(1);
    do_run(1, 1'b0);
    n_tests++;
    if (cap_x.size() !== 7 || done_cyc !== 8) begin
      n_fail++;
      $display("[TB] FAIL k1_frame: got %0d beats, done at %0d, expected 7 beats, done at 8", cap_x.size(), done_cyc);
    end
    for (int b = 0; b < cap_x.size() && b < exp_x.size(); b++) begin
      n_tests++;
      if ({cap_x[b], cap_z1[b], cap_z2[b], cap_last[b]} !== {exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]}) begin
        n_fail++;
        $display("[TB] FAIL k1_beat%0d: got %b%b%b%b, expected %b%b%b%b", b + 1,
                 cap_x[b], cap_z1[b], cap_z2[b], cap_last[b], exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]);
      end
    end
  endtask

  // First frame fills the whole buffer so later random interleaver reads hit known bits.
  task automatic test_random;
    int k, bad_beats, bad_drive;
    for (int f = 0; f < 7; f++) begin
      k = (f == 0) ? K_MAX : $urandom_range(1, 24);
      if (f > 0) for (int j = 0; j < DEPTH; j++) perm[j] = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < k; i++) frame_bits[i] = 1'($urandom_range(0, 1));
      do_load(k, $urandom_range(0, 2));
      n_tests++;
      if (acc_cnt !== k || load_ok !== 1'b1) begin
        n_fail++; $display("[TB] FAIL rand%0d_load: got %0d accepts, expected %0d", f, acc_cnt, k);
      end
      build_expected(k);
      do_run(k, f > 0);
      n_tests++;
      if (cap_x.size() !== k + 6 || first_beat !== 1 || last_beat !== k + 6) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_beats: got %0d beats at %0d..%0d, expected %0d at 1..%0d",
                 f, cap_x.size(), first_beat, last_beat, k + 6, k + 6);
      end
      bad_beats = 0;
      for (int b = 0; b < cap_x.size() && b < exp_x.size(); b++)
        if ({cap_x[b], cap_z1[b], cap_z2[b], cap_last[b]} !== {exp_x[b], exp_z1[b], exp_z2[b], exp_last[b]})
          bad_beats++;
      n_tests++;
      if (bad_beats !== 0) begin
        n_fail++; $display("[TB] FAIL rand%0d_data: got %0d wrong beats, expected 0", f, bad_beats);
      end
      bad_drive = 0;
      for (int i = 0; i < k && i < cap_e2.size(); i++)
        if (cap_e2[i] !== exp_e2[i] || cap_e1[i] !== frame_bits[i] || cap_addr[i] !== i) bad_drive++;
      n_tests++;
      if (bad_drive !== 0) begin
        n_fail++; $display("[TB] FAIL rand%0d_drive: got %0d wrong ENC cycles, expected 0", f, bad_drive);
      end
      n_tests++;
      if (done_cyc !== k + 7 || done_cnt !== 1 || err_cnt !== 0) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_status: got done at %0d x%0d, err x%0d, expected done at %0d x1, err x0",
                 f, done_cyc, done_cnt, err_cnt, k + 7);
      end
    end
    for (int j = 0; j < DEPTH; j++) perm[j] = j;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      perm[i]    = i;
      ref_mem[i] = 1'b0;
    end
    test_reset();
    test_zero_frame();
    test_pattern();
    test_bad_len();
    test_gap_load();
    test_reversed();
    test_reset_mid_enc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/turbo_frame_ctrl.md
TURBO_FRAME_CTRL -- requirements
Module: turbo_frame_ctrl

Interface
REQ-001 Parameter K_MAX, default 256: maximum frame length in bits.
REQ-002 Parameter AW, default 8: buffer/interleaver address width, 2^AW >= K_MAX.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_N  in  1  synchronous active-low reset.
REQ-005 start  in  1  one-cycle frame request, sampled in IDLE only.
REQ-006 frame_len  in  AW+1  frame length K, sampled with start.
REQ-007 in_valid  in  1  / in_bit  in  1 / in_ready  out  1  systematic bit input, valid/ready handshake.
REQ-008 il_addr  out  AW  interleaver ROM address; il_data  in  AW  permuted index, combinational same-cycle return.
REQ-009 enc_rst  out  1  active-high reset to both RSC encoders.
REQ-010 enc1_bin, enc1_mode, enc2_bin, enc2_mode  out  1 each  encoder input bit and termination-mode select.
REQ-011 enc1_x, enc1_z, enc2_x, enc2_z  in  1 each  encoder systematic and parity outputs.
REQ-012 out_valid, out_x, out_z1, out_z2, out_last  out  1 each  registered coded output triple.
REQ-013 busy, done, err  out  1 each  status; done and err are one-cycle pulses.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, ENC, TAIL1, TAIL2, DONE.
REQ-015 IDLE: start with 1 <= frame_len <= K_MAX -> LOAD and capture K; start with any other frame_len -> err pulse next cycle, remain IDLE.
REQ-016 LOAD: in_ready=1; each accepted bit (in_valid & in_ready) written to buf[n], n = 0..K-1; after the K-th accept -> ENC, in_ready=0 on the following cycle.
REQ-017 enc_rst=1 in IDLE and LOAD, 0 in all other states.
REQ-018 ENC: K cycles, index i = 0..K-1; il_addr=i, enc1_bin=buf[i], enc2_bin=buf[il_data], enc1_mode=enc2_mode=0.
REQ-019 TAIL1: exactly 3 cycles; enc1_mode=1, enc2_mode=1 (encoder 2 frozen).
REQ-020 TAIL2: exactly 3 cycles; enc1_mode=1, enc2_mode=1.
REQ-021 DONE: one cycle, done=1, then IDLE.
REQ-022 Outputs SHALL be registered with 1-cycle latency from the drive cycle: ENC beat -> out_x=buf[i], out_z1=enc1_z, out_z2=enc2_z; TAIL1 beat -> out_x=enc1_x, out_z1=enc1_z, out_z2=0; TAIL2 beat -> out_x=enc2_x, out_z1=0, out_z2=enc2_z.
REQ-023 out_valid=1 for exactly K+6 consecutive cycles per frame, with no gaps.
REQ-024 out_last=1 only on the final (K+6)-th beat.
REQ-025 No output backpressure; downstream SHALL always accept.
REQ-026 busy=1 in every state except IDLE.
REQ-027 start while busy SHALL be ignored, with no err.
REQ-028 in_valid outside LOAD SHALL be ignored (in_ready=0).
REQ-029 il_data >= K is not checked; the buffer is read at il_data[AW-1:0].
REQ-030 K=1 is legal: 1 ENC cycle, 7 output beats.
REQ-031 Counters SHALL not wrap: the ENC counter stops at K-1, the tail counter at 2.

Reset
REQ-032 rst_N=0 at any edge -> IDLE next cycle, from any state including mid-LOAD, mid-ENC or mid-tail.
REQ-033 During and after reset: in_ready=0, out_valid=0, out_x=out_z1=out_z2=out_last=0, busy=done=err=0, enc_rst=1, enc modes 0, il_addr=0.
REQ-034 Buffer contents SHALL not be cleared by reset; a frame aborted by reset produces no further output beats.

Verification
REQ-035 frame_len=8, all-zero bits, identity interleaver -> 14 beats, all out bits 0, out_last on beat 14, done one cycle later.
REQ-036 frame_len=4, bits 1,0,1,1, identity interleaver -> out_x beats 1-4 = 1,0,1,1; out_z1 equals out_z2 on beats 1-4; beats 5-10 match the encoder golden model.
REQ-037 frame_len=0 and frame_len=K_MAX+1 with start -> err pulse, busy stays 0, in_ready stays 0.
REQ-038 in_valid toggled every other cycle during LOAD -> exactly K bits accepted, ENC entered only after the K-th accept.
REQ-039 rst_N=0 on the 2nd ENC cycle -> IDLE next cycle, out_valid=0; a new frame with frame_len=1 then yields 7 beats.
REQ-040 Reversed interleaver (il_data=K-1-i), frame_len=4, bits 1,0,0,0 -> enc2_bin sequence 0,0,0,1.
